mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-003 I_Miss  in  1  I-cache refill request; held high until I_Fill_Done.
REQ-004 I_Miss_Addr  in  16  byte address of I-cache missing word.
REQ-005 D_Miss  in  1  D-cache refill request; held high until D_Fill_Done.
REQ-006 D_Miss_Addr  in  16  byte address of D-cache missing word.
REQ-007 D_Write  in  1  D-cache write-through request; held high until D_Write_Done.
REQ-008 D_Write_Addr / D_Write_Data  in  16 / 16  write-through address and data.
REQ-009 Mem_Enable / Mem_Write  out  1 / 1  memory access strobe; write qualifier.
REQ-010 Mem_Addr / Mem_Data_Out  out  16 / 16  memory address; write data.
REQ-011 Mem_Data_In / Mem_Data_Valid  in  16 / 1  read data; valid, exactly 4 cycles after its read issue.
REQ-012 Fill_Addr / Fill_Data  out  16 / 16  cache word address and data being written.
REQ-013 I_Fill_WE / D_Fill_WE  out  1 / 1  per-cache fill write strobe.
REQ-014 I_Fill_Done / D_Fill_Done / D_Write_Done  out  1 each  single-cycle completion pulses.
REQ-015 Busy  out  1  high in any non-IDLE state.

Function
REQ-016 States SHALL be IDLE, FILL_I, FILL_D, WRITE_D.
REQ-017 In IDLE the arbiter SHALL sample requests each edge and enter the granted state the next cycle; D_Miss and D_Write SHALL never both be high (D-cache contract), and D_Write counts as a D request.
REQ-018 When I and D requests are both pending, grant SHALL go to the side not granted last (round-robin; after reset, D wins); a single pending request SHALL be granted immediately.
REQ-019 Block = 8 words (16 bytes); fill base = {Miss_Addr[15:4], 4'h0}, word k address = base + 2k.
REQ-020 In FILL_x, issue counter SHALL drive Mem_Enable=1, Mem_Write=0, Mem_Addr = word k for k = 0..7 on 8 consecutive cycles, then hold Mem_Enable=0.
REQ-021 Receive counter SHALL advance on each Mem_Data_Valid; on each valid, Fill_Data=Mem_Data_In, Fill_Addr = word (receive count), and the granted side's Fill_WE=1 for that cycle only.
REQ-022 The 8th received word SHALL assert x_Fill_Done in the same cycle; state returns to IDLE next edge; fill occupancy = 12 cycles.
REQ-023 WRITE_D SHALL drive Mem_Enable=1, Mem_Write=1, Mem_Addr=D_Write_Addr, Mem_Data_Out=D_Write_Data for one cycle, pulse D_Write_Done in that cycle, then return to IDLE.
REQ-024 A request deasserted mid-fill SHALL NOT abort the fill; all 8 words and Done still issue.
REQ-025 Mem_Data_Valid outside FILL_x SHALL be ignored (no Fill_WE).
REQ-026 Counters are 3-bit and SHALL NOT wrap within a fill; both clear on entry to FILL_x.
REQ-027 Both Fill_WE strobes SHALL never be high together; non-granted side's strobe and Done stay 0.
REQ-028 When not driven, Mem_Addr, Mem_Data_Out, Fill_Addr, Fill_Data SHALL be 16'h0000.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, counters 0, round-robin pointer to "last=I", and every output 0, including mid-fill.
REQ-030 After rst release, the first request SHALL be serviced per REQ-017; memory returns from a pre-reset fill are ignored.

Structure
REQ-031 Shared package SHALL hold BLOCK_WORDS=8, MEM_LATENCY=4, WORD_BYTES=2 and the state encoding.
REQ-032 One sub-module, fill_counter (3-bit, clear/increment/terminal-count), instantiated twice (issue, receive).

Verification
REQ-033 I_Miss, I_Miss_Addr=16'h1812 -> Mem_Addr 1810..181E on cycles 1-8; I_Fill_WE with Fill_Addr 1810..181E on cycles 5-12; I_Fill_Done on cycle 12.
REQ-034 I_Miss and D_Miss (16'h0413) both high after reset -> D fill (0410..041E) first, then I fill; no overlap of Fill_WE.
REQ-035 D_Write, Addr=16'h1913, Data=16'h0002 -> one cycle Mem_Write=1, Mem_Addr=1913, Mem_Data_Out=0002, D_Write_Done same cycle.
REQ-036 rst=0 at fill cycle 6 -> outputs 0 immediately; later Mem_Data_Valid produces no Fill_WE; new I_Miss after release fills correctly.
REQ-037 Continuous I_Miss and D_Miss -> grants alternate D, I, D, I over 4 fills.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants, state encoding and address helpers for the I/D refill arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LATENCY = 4;
  localparam int unsigned WORD_BYTES  = 2;
  localparam int unsigned CNT_W       = $clog2(BLOCK_WORDS);
  localparam int unsigned BLOCK_BYTES = BLOCK_WORDS * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_I  = 2'd1,
    FILL_D  = 2'd2,
    WRITE_D = 2'd3
  } state_e;

  // One memory-side command as driven on the Mem_* pins.
  typedef struct packed {
    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_cmd_t;

  // One cache-side fill write as driven on the Fill_* pins.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fill_word_t;

  // Aligns a miss address down to the start of its block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(BLOCK_BYTES - 1);
  endfunction

  // Byte address of word idx within the block starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + ADDR_W'(ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Saturating word counter for one block: clears, increments, flags the last word.
module fill_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Terminal count: all ones means the last word of the block.
  assign tc = &cnt;

  // Count register; holds at terminal count so it never wraps inside a block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache refills, D-cache refills and D-cache write-throughs onto one memory port.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              I_Miss,
  input  logic [ADDR_W-1:0] I_Miss_Addr,
  input  logic              D_Miss,
  input  logic [ADDR_W-1:0] D_Miss_Addr,
  input  logic              D_Write,
  input  logic [ADDR_W-1:0] D_Write_Addr,
  input  logic [DATA_W-1:0] D_Write_Data,
  output logic              Mem_Enable,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data_Out,
  input  logic [DATA_W-1:0] Mem_Data_In,
  input  logic              Mem_Data_Valid,
  output logic [ADDR_W-1:0] Fill_Addr,
  output logic [DATA_W-1:0] Fill_Data,
  output logic              I_Fill_WE,
  output logic              D_Fill_WE,
  output logic              I_Fill_Done,
  output logic              D_Fill_Done,
  output logic              D_Write_Done,
  output logic              Busy
);

  state_e            state, state_nxt;
  logic              last_i, last_i_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic              issue_stop, issue_stop_nxt;
  logic [MEM_LATENCY-1:0] issue_pipe;

  logic              in_fill;
  logic              d_req;
  logic              issue_en;
  logic              rx_en;
  logic              cnt_clr;
  logic [CNT_W-1:0]  issue_cnt, rx_cnt;
  logic              issue_tc, rx_tc;
  mem_cmd_t          cmd;
  fill_word_t        fill_w;

  assign in_fill  = (state == FILL_I) || (state == FILL_D);
  assign d_req    = D_Miss || D_Write;
  assign cnt_clr  = (state == IDLE);
  assign issue_en = in_fill && !issue_stop;
  // Only returns lining up with one of our own reads count; stale pre-reset data is dropped.
  assign rx_en    = in_fill && Mem_Data_Valid && issue_pipe[MEM_LATENCY-1];

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (issue_en),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  fill_counter #(.W(CNT_W)) u_rx_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (rx_en),
    .cnt   (rx_cnt),
    .tc    (rx_tc)
  );

  // State, round-robin pointer, latched block base and issue-stop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_i     <= 1'b1;
      base       <= '0;
      issue_stop <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_i     <= last_i_nxt;
      base       <= base_nxt;
      issue_stop <= issue_stop_nxt;
    end
  end

  // Tracks which of the last MEM_LATENCY cycles issued a read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_pipe <= '0;
    end else begin
      issue_pipe <= {issue_pipe[MEM_LATENCY-2:0], issue_en};
    end
  end

  // Next-state, grant and output decode.
  always_comb begin
    state_nxt      = state;
    last_i_nxt     = last_i;
    base_nxt       = base;
    issue_stop_nxt = issue_stop;
    cmd            = '0;
    fill_w         = '0;
    I_Fill_WE      = 1'b0;
    D_Fill_WE      = 1'b0;
    I_Fill_Done    = 1'b0;
    D_Fill_Done    = 1'b0;
    D_Write_Done   = 1'b0;
    Busy           = 1'b0;

    case (state)
      IDLE: begin
        issue_stop_nxt = 1'b0;
        if (I_Miss && (!d_req || !last_i)) begin
          state_nxt  = FILL_I;
          last_i_nxt = 1'b1;
          base_nxt   = block_base(I_Miss_Addr);
        end else if (d_req) begin
          last_i_nxt = 1'b0;
          if (D_Write) begin
            state_nxt = WRITE_D;
          end else begin
            state_nxt = FILL_D;
            base_nxt  = block_base(D_Miss_Addr);
          end
        end
      end

      FILL_I, FILL_D: begin
        Busy = 1'b1;
        if (issue_en) begin
          cmd.en   = 1'b1;
          cmd.addr = word_addr(base, issue_cnt);
          if (issue_tc) begin
            issue_stop_nxt = 1'b1;
          end
        end
        if (rx_en) begin
          fill_w.addr = word_addr(base, rx_cnt);
          fill_w.data = Mem_Data_In;
          I_Fill_WE   = (state == FILL_I);
          D_Fill_WE   = (state == FILL_D);
          if (rx_tc) begin
            I_Fill_Done = (state == FILL_I);
            D_Fill_Done = (state == FILL_D);
            state_nxt   = IDLE;
          end
        end
      end

      WRITE_D: begin
        Busy         = 1'b1;
        cmd.en       = 1'b1;
        cmd.wr       = 1'b1;
        cmd.addr     = D_Write_Addr;
        cmd.data     = D_Write_Data;
        D_Write_Done = 1'b1;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign Mem_Enable   = cmd.en;
  assign Mem_Write    = cmd.wr;
  assign Mem_Addr     = cmd.addr;
  assign Mem_Data_Out = cmd.data;
  assign Fill_Addr    = fill_w.addr;
  assign Fill_Data    = fill_w.data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory/fill events, a monitor checks them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        I_Miss = 1'b0;
  logic [15:0] I_Miss_Addr = '0;
  logic        D_Miss = 1'b0;
  logic [15:0] D_Miss_Addr = '0;
  logic        D_Write = 1'b0;
  logic [15:0] D_Write_Addr = '0;
  logic [15:0] D_Write_Data = '0;
  logic        Mem_Enable, Mem_Write;
  logic [15:0] Mem_Addr, Mem_Data_Out;
  logic [15:0] Mem_Data_In = '0;
  logic        Mem_Data_Valid = 1'b0;
  logic [15:0] Fill_Addr, Fill_Data;
  logic        I_Fill_WE, D_Fill_WE, I_Fill_Done, D_Fill_Done, D_Write_Done, Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        wdone;
  } mem_ev_t;

  typedef struct {
    int          cyc;
    logic        side_i;
    logic [15:0] addr;
    logic [15:0] data;
    logic        done;
  } fill_ev_t;

  mem_ev_t  mq[$];
  fill_ev_t fq[$];
  mem_ev_t  me;
  fill_ev_t fe;

  typedef struct packed {
    logic        v;
    logic [15:0] a;
  } slot_t;
  slot_t cap = '0;
  slot_t st [4] = '{default: '0};

  mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .I_Miss         (I_Miss),
    .I_Miss_Addr    (I_Miss_Addr),
    .D_Miss         (D_Miss),
    .D_Miss_Addr    (D_Miss_Addr),
    .D_Write        (D_Write),
    .D_Write_Addr   (D_Write_Addr),
    .D_Write_Data   (D_Write_Data),
    .Mem_Enable     (Mem_Enable),
    .Mem_Write      (Mem_Write),
    .Mem_Addr       (Mem_Addr),
    .Mem_Data_Out   (Mem_Data_Out),
    .Mem_Data_In    (Mem_Data_In),
    .Mem_Data_Valid (Mem_Data_Valid),
    .Fill_Addr      (Fill_Addr),
    .Fill_Data      (Fill_Data),
    .I_Fill_WE      (I_Fill_WE),
    .D_Fill_WE      (D_Fill_WE),
    .I_Fill_Done    (I_Fill_Done),
    .D_Fill_Done    (D_Fill_Done),
    .D_Write_Done   (D_Write_Done),
    .Busy           (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: a read seen in cycle n returns addr^A5A5 during cycle n+4.
  always @(negedge clk) cap = '{v: Mem_Enable && !Mem_Write, a: Mem_Addr};

  always @(posedge clk) begin
    #1;
    st[3] = st[2];
    st[2] = st[1];
    st[1] = st[0];
    st[0] = cap;
    Mem_Data_Valid = st[3].v;
    Mem_Data_In    = st[3].v ? (st[3].a ^ 16'hA5A5) : 16'h0000;
  end

  // Monitor: pops an expectation whenever the DUT presents a memory command or fill write.
  always @(negedge clk) begin
    if (rst) begin
      if (Mem_Enable) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected cyc=%0d addr=%h wr=%b", cyc, Mem_Addr, Mem_Write);
        end else begin
          me = mq.pop_front();
          if (cyc != me.cyc || Mem_Write != me.wr || Mem_Addr != me.addr ||
              Mem_Data_Out != me.data || D_Write_Done != me.wdone) begin
            errors++;
            $display("FAIL mem_cmd got cyc=%0d wr=%b addr=%h dout=%h wdone=%b want cyc=%0d wr=%b addr=%h dout=%h wdone=%b",
                     cyc, Mem_Write, Mem_Addr, Mem_Data_Out, D_Write_Done,
                     me.cyc, me.wr, me.addr, me.data, me.wdone);
          end
        end
      end else begin
        checks++;
        if (Mem_Write || Mem_Addr != 16'h0 || Mem_Data_Out != 16'h0 || D_Write_Done) begin
          errors++;
          $display("FAIL mem_idle_zero cyc=%0d got wr=%b addr=%h dout=%h wdone=%b want all 0",
                   cyc, Mem_Write, Mem_Addr, Mem_Data_Out, D_Write_Done);
        end
      end

      if (I_Fill_WE || D_Fill_WE) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL fill_unexpected cyc=%0d iwe=%b dwe=%b addr=%h", cyc, I_Fill_WE, D_Fill_WE, Fill_Addr);
        end else begin
          fe = fq.pop_front();
          if (cyc != fe.cyc || I_Fill_WE != fe.side_i || D_Fill_WE != !fe.side_i ||
              Fill_Addr != fe.addr || Fill_Data != fe.data ||
              I_Fill_Done != (fe.done && fe.side_i) || D_Fill_Done != (fe.done && !fe.side_i)) begin
            errors++;
            $display("FAIL fill_word got cyc=%0d iwe=%b dwe=%b addr=%h data=%h idone=%b ddone=%b want cyc=%0d side_i=%b addr=%h data=%h done=%b",
                     cyc, I_Fill_WE, D_Fill_WE, Fill_Addr, Fill_Data, I_Fill_Done, D_Fill_Done,
                     fe.cyc, fe.side_i, fe.addr, fe.data, fe.done);
          end
        end
      end else begin
        checks++;
        if (Fill_Addr != 16'h0 || Fill_Data != 16'h0 || I_Fill_Done || D_Fill_Done) begin
          errors++;
          $display("FAIL fill_idle_zero cyc=%0d got addr=%h data=%h idone=%b ddone=%b want all 0",
                   cyc, Fill_Addr, Fill_Data, I_Fill_Done, D_Fill_Done);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queues a refill of the block holding req_addr that starts in cycle s.
  task automatic push_fill(input int s, input logic side_i, input logic [15:0] req_addr,
                           input int n_mem, input int n_fill);
    logic [15:0] base;
    logic [15:0] a;
    base = req_addr & 16'hFFF0;
    for (int k = 0; k < n_mem; k++) begin
      a = base + 16'(2 * k);
      mq.push_back('{cyc: s + k, wr: 1'b0, addr: a, data: 16'h0000, wdone: 1'b0});
    end
    for (int k = 0; k < n_fill; k++) begin
      a = base + 16'(2 * k);
      fq.push_back('{cyc: s + 4 + k, side_i: side_i, addr: a, data: a ^ 16'hA5A5, done: (k == 7)});
    end
  endtask

  // Waits (bounded) for any completion pulse; reports which side finished.
  task automatic wait_done(input string nm, output logic got_i, output logic got_d);
    got_i = 1'b0;
    got_d = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (I_Fill_Done || D_Fill_Done || D_Write_Done) begin
        got_i = I_Fill_Done;
        got_d = D_Fill_Done || D_Write_Done;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout_%s no completion pulse within 40 cycles", nm);
  endtask

  task automatic chk_bit(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic chk_outs_zero(input string nm);
    logic [71:0] all;
    all = {Mem_Enable, Mem_Write, Mem_Addr, Mem_Data_Out, Fill_Addr, Fill_Data,
           I_Fill_WE, D_Fill_WE, I_Fill_Done, D_Fill_Done, D_Write_Done, Busy};
    checks++;
    if (all !== 72'h0) begin
      errors++;
      $display("FAIL %s outputs got=%h want=0", nm, all);
    end
  endtask

  initial begin
    int c;
    logic gi, gd;

    // Reset state.
    #3;
    chk_outs_zero("reset_outputs");
    step();
    step();
    rst = 1'b1;
    step();

    // Both sides miss after reset: D first, then strict alternation over four fills.
    c = cyc;
    D_Miss = 1'b1; D_Miss_Addr = 16'h0413;
    I_Miss = 1'b1; I_Miss_Addr = 16'h2A37;
    push_fill(c + 1,  1'b0, 16'h0413, 8, 8);
    push_fill(c + 14, 1'b1, 16'h2A37, 8, 8);
    push_fill(c + 27, 1'b0, 16'h0B58, 8, 8);
    push_fill(c + 40, 1'b1, 16'hFFF9, 8, 8);
    for (int n = 0; n < 4; n++) begin
      wait_done("alt", gi, gd);
      #1;
      if (n == 3) begin
        I_Miss = 1'b0;
        D_Miss = 1'b0;
      end else if (gd) begin
        D_Miss_Addr = 16'h0B58;
      end else if (gi) begin
        I_Miss_Addr = 16'hFFF9;
      end
    end
    repeat (3) step();

    // Single I miss: words 1810..181E issued cycles 1-8, filled cycles 5-12.
    c = cyc;
    I_Miss = 1'b1; I_Miss_Addr = 16'h1812;
    push_fill(c + 1, 1'b1, 16'h1812, 8, 8);
    @(negedge clk);
    chk_bit("busy_idle", Busy, 1'b0);
    @(negedge clk);
    chk_bit("busy_fill", Busy, 1'b1);
    wait_done("ifill", gi, gd);
    #1;
    I_Miss = 1'b0;
    repeat (3) step();

    // D write-through: one-cycle write with the completion pulse in the same cycle.
    c = cyc;
    D_Write = 1'b1; D_Write_Addr = 16'h1913; D_Write_Data = 16'h0002;
    mq.push_back('{cyc: c + 1, wr: 1'b1, addr: 16'h1913, data: 16'h0002, wdone: 1'b1});
    wait_done("write", gi, gd);
    #1;
    D_Write = 1'b0;
    repeat (3) step();

    // Reset in fill cycle 6: outputs drop immediately, stale returns are ignored.
    c = cyc;
    I_Miss = 1'b1; I_Miss_Addr = 16'h1812;
    push_fill(c + 1, 1'b1, 16'h1812, 5, 1);
    repeat (6) step();
    rst = 1'b0;
    I_Miss = 1'b0;
    #1;
    chk_outs_zero("midfill_reset");
    step();
    step();
    rst = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (Mem_Data_Valid) begin
        chk_bit("stale_no_we", I_Fill_WE || D_Fill_WE, 1'b0);
      end
    end
    step();

    // Fresh I miss after reset release fills normally.
    c = cyc;
    I_Miss = 1'b1; I_Miss_Addr = 16'hABCD;
    push_fill(c + 1, 1'b1, 16'hABCD, 8, 8);
    wait_done("postreset", gi, gd);
    #1;
    I_Miss = 1'b0;
    repeat (20) step();

    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL mem_queue_drain left=%0d want 0", mq.size());
    end
    checks++;
    if (fq.size() != 0) begin
      errors++;
      $display("FAIL fill_queue_drain left=%0d want 0", fq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
